nou_decode_mc: RTL and testbench

Parametrised multi-channel decode stage for the NOU pipeline. It sits between fetch and the per-request-type execution units. It takes one fetched entry per cycle and gates issue on unit-output-vector hazards. It then routes the decoded command into one of `NUM_CH` single-entry output registers, or into the invalid-request register (IRR), each with its own valid/ready handshake. Unlike the fixed five-register decode, every output applies backpressure, and issue stalls are counted.

---
 rtl/nou_decode_mc.sv | 103 ++++++++++
 tb/tb_nou_decode_mc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/nou_decode_mc.sv
// Multi-channel decode stage: gates fetched entries on unit hazards and routes each one
// into a per-request-type output register or the invalid-request register (IRR).
module nou_decode_mc #(
    parameter int NUM_CH      = 5,
    parameter int SID_W       = 8,
    parameter int CMD_W       = 64,
    parameter int RTYPE_W     = 4,
    parameter int UOV_W       = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                                  clk,
    input  logic                                  rstn,
    input  logic [UOV_W+CMD_W+SID_W:0]            entry_input,
    input  logic                                  entry_input_valid,
    output logic                                  decode_issue_ack,
    input  logic [UOV_W-1:0]                      unit_output_vector,
    output logic [NUM_CH-1:0]                     ch_vld,
    input  logic [NUM_CH-1:0]                     ch_rdy,
    output logic [NUM_CH*SID_W-1:0]               ch_sid,
    output logic [NUM_CH*(CMD_W-RTYPE_W)-1:0]     ch_payload,
    output logic                                  irr_vld,
    input  logic                                  irr_rdy,
    output logic [SID_W-1:0]                      irr_sid,
    output logic [RTYPE_W-1:0]                    irr_rtype,
    output logic [STALL_CNT_W-1:0]                stall_cnt
);
    localparam int PW = CMD_W - RTYPE_W;

    logic                ent_vld;
    logic [SID_W-1:0]    sid;
    logic [CMD_W-1:0]    cmd;
    logic [UOV_W-1:0]    unit_mask;
    logic [RTYPE_W-1:0]  rtype;
    logic [PW-1:0]       payload;
    logic                to_irr;
    logic                hazard;
    logic                target_free;
    logic                wr;
    logic                ld_irr;
    logic [NUM_CH-1:0]   ld_ch;

    assign ent_vld   = entry_input[0];
    assign sid       = entry_input[SID_W:1];
    assign cmd       = entry_input[SID_W+CMD_W:SID_W+1];
    assign unit_mask = entry_input[UOV_W+CMD_W+SID_W:CMD_W+SID_W+1];
    assign rtype     = cmd[RTYPE_W-1:0];
    assign payload   = cmd[CMD_W-1:RTYPE_W];
    assign to_irr    = (32'(rtype) >= 32'(NUM_CH));
    assign hazard    = |(unit_mask & unit_output_vector);

    // Handshake: a slot transfers on vld & rdy; a slot is free when empty or draining
    // this cycle, so a draining slot may be refilled in the same cycle.
    always_comb begin
        target_free = !irr_vld || irr_rdy;
        ld_ch       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!to_irr && rtype == RTYPE_W'(k)) target_free = !ch_vld[k] || ch_rdy[k];
        end
        decode_issue_ack = rstn && entry_input_valid && (!ent_vld || (!hazard && target_free));
        wr     = decode_issue_ack && ent_vld;
        ld_irr = wr && to_irr;
        for (int k = 0; k < NUM_CH; k++) begin
            ld_ch[k] = wr && !to_irr && (rtype == RTYPE_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            ch_vld     <= '0;
            ch_sid     <= '0;
            ch_payload <= '0;
            irr_vld    <= 1'b0;
            irr_sid    <= '0;
            irr_rtype  <= '0;
            stall_cnt  <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ld_ch[k]) begin
                    ch_vld[k]                  <= 1'b1;
                    ch_sid[k*SID_W +: SID_W]   <= sid;
                    ch_payload[k*PW +: PW]     <= payload;
                end else if (ch_rdy[k]) begin
                    ch_vld[k] <= 1'b0;
                end
            end

            if (ld_irr) begin
                irr_vld   <= 1'b1;
                irr_sid   <= sid;
                irr_rtype <= rtype;
            end else if (irr_rdy) begin
                irr_vld <= 1'b0;
            end

            // Counts only the current stall; any ack or idle fetch cycle restarts it.
            if (entry_input_valid && !decode_issue_ack) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
            end else begin
                stall_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_nou_decode_mc.sv
// Bench for nou_decode_mc: directed scenarios followed by random traffic, all checked
// cycle by cycle against an array-based reference model of the output slots.
module tb_nou_decode_mc;
    localparam int NUM_CH  = 5;
    localparam int SID_W   = 8;
    localparam int CMD_W   = 64;
    localparam int RTYPE_W = 4;
    localparam int UOV_W   = 8;
    localparam int SC_W    = 4;
    localparam int PW      = CMD_W - RTYPE_W;
    localparam int SC_MAX  = (1 << SC_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          rstn;
    logic                          eiv;
    logic                          drv_ev;
    logic [SID_W-1:0]              drv_sid;
    logic [CMD_W-1:0]              drv_cmd;
    logic [UOV_W-1:0]              drv_mask;
    logic [UOV_W+CMD_W+SID_W:0]    entry_input;
    logic                          decode_issue_ack;
    logic [UOV_W-1:0]              uov;
    logic [NUM_CH-1:0]             ch_vld;
    logic [NUM_CH-1:0]             ch_rdy;
    logic [NUM_CH*SID_W-1:0]       ch_sid;
    logic [NUM_CH*PW-1:0]          ch_payload;
    logic                          irr_vld;
    logic                          irr_rdy;
    logic [SID_W-1:0]              irr_sid;
    logic [RTYPE_W-1:0]            irr_rtype;
    logic [SC_W-1:0]               stall_cnt;

    assign entry_input = {drv_mask, drv_cmd, drv_sid, drv_ev};

    nou_decode_mc #(
        .NUM_CH(NUM_CH), .SID_W(SID_W), .CMD_W(CMD_W),
        .RTYPE_W(RTYPE_W), .UOV_W(UOV_W), .STALL_CNT_W(SC_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .entry_input(entry_input), .entry_input_valid(eiv),
        .decode_issue_ack(decode_issue_ack), .unit_output_vector(uov),
        .ch_vld(ch_vld), .ch_rdy(ch_rdy), .ch_sid(ch_sid), .ch_payload(ch_payload),
        .irr_vld(irr_vld), .irr_rdy(irr_rdy), .irr_sid(irr_sid), .irr_rtype(irr_rtype),
        .stall_cnt(stall_cnt)
    );

    // Reference model state
    logic               m_vld[NUM_CH];
    logic [SID_W-1:0]   m_sid[NUM_CH];
    logic [PW-1:0]      m_pay[NUM_CH];
    logic               m_irr_vld;
    logic [SID_W-1:0]   m_irr_sid;
    logic [RTYPE_W-1:0] m_irr_rtype;
    int                 m_stall;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic ev, input logic [UOV_W-1:0] mask, input int rt,
                       input logic [SID_W-1:0] s);
        logic [PW-1:0] pl;
        pl       = {28'($urandom), $urandom};
        drv_ev   = ev;
        drv_mask = mask;
        drv_sid  = s;
        drv_cmd  = {pl, RTYPE_W'(rt)};
    endtask

    task automatic model_clear();
        for (int k = 0; k < NUM_CH; k++) begin
            m_vld[k] = 1'b0; m_sid[k] = '0; m_pay[k] = '0;
        end
        m_irr_vld = 1'b0; m_irr_sid = '0; m_irr_rtype = '0; m_stall = 0;
    endtask

    // One clock: compare DUT against the model, then advance the model across the edge.
    task automatic step();
        int            rt;
        logic          hz, free, exp_ack;
        #1;
        rt   = int'(drv_cmd[RTYPE_W-1:0]);
        hz   = |(drv_mask & uov);
        if (rt < NUM_CH) free = !m_vld[rt] || ch_rdy[rt];
        else             free = !m_irr_vld || irr_rdy;
        exp_ack = rstn && eiv && (!drv_ev || (!hz && free));

        check_eq("ack", 64'(decode_issue_ack), 64'(exp_ack));
        for (int k = 0; k < NUM_CH; k++) begin
            check_eq($sformatf("ch%0d_vld", k), 64'(ch_vld[k]), 64'(m_vld[k]));
            check_eq($sformatf("ch%0d_sid", k), 64'(ch_sid[k*SID_W +: SID_W]), 64'(m_sid[k]));
            check_eq($sformatf("ch%0d_payload", k), 64'(ch_payload[k*PW +: PW]), 64'(m_pay[k]));
        end
        check_eq("irr_vld", 64'(irr_vld), 64'(m_irr_vld));
        check_eq("irr_sid", 64'(irr_sid), 64'(m_irr_sid));
        check_eq("irr_rtype", 64'(irr_rtype), 64'(m_irr_rtype));
        check_eq("stall_cnt", 64'(stall_cnt), 64'(m_stall));

        @(posedge clk);
        if (!rstn) begin
            model_clear();
        end else begin
            if (eiv && !exp_ack) m_stall = (m_stall == SC_MAX) ? SC_MAX : m_stall + 1;
            else                 m_stall = 0;
            for (int k = 0; k < NUM_CH; k++) if (m_vld[k] && ch_rdy[k]) m_vld[k] = 1'b0;
            if (m_irr_vld && irr_rdy) m_irr_vld = 1'b0;
            if (exp_ack && drv_ev) begin
                if (rt < NUM_CH) begin
                    m_vld[rt] = 1'b1;
                    m_sid[rt] = drv_sid;
                    m_pay[rt] = drv_cmd[CMD_W-1:RTYPE_W];
                end else begin
                    m_irr_vld   = 1'b1;
                    m_irr_sid   = drv_sid;
                    m_irr_rtype = RTYPE_W'(rt);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_clear();
        rstn = 1'b0; eiv = 1'b1; uov = '0; ch_rdy = '1; irr_rdy = 1'b1;
        put(1'b1, '0, 0, 8'h10);
        @(posedge clk);
        @(negedge clk);

        // Reset held with a pending entry
        repeat (3) step();
        rstn = 1'b1;
        #1 check_eq("rst_release_ack", 64'(decode_issue_ack), 64'd1);

        // Routing to every channel, then an out-of-range rtype to the IRR
        for (int k = 0; k < NUM_CH; k++) begin
            put(1'b1, '0, k, SID_W'(8'h10 + k));
            step();
        end
        put(1'b1, '0, 9, 8'h20);
        step();
        eiv = 1'b0;
        #1 check_eq("irr_rtype_9", 64'(irr_rtype), 64'd9);
        step();

        // Hazard stall for six cycles
        eiv = 1'b1; uov = 8'h04;
        put(1'b1, 8'h04, 1, 8'h21);
        repeat (6) step();
        check_eq("haz_stall_6", 64'(stall_cnt), 64'd6);
        uov = 8'h00;
        #1 check_eq("haz_release_ack", 64'(decode_issue_ack), 64'd1);
        step();
        eiv = 1'b0;
        #1 check_eq("haz_stall_clear", 64'(stall_cnt), 64'd0);
        step();

        // Backpressure on channel 2, then same-cycle drain and refill
        eiv = 1'b1; ch_rdy[2] = 1'b0;
        put(1'b1, '0, 2, 8'h31);
        step();
        put(1'b1, '0, 2, 8'h32);
        repeat (2) step();
        ch_rdy[2] = 1'b1;
        #1 check_eq("bp_refill_ack", 64'(decode_issue_ack), 64'd1);
        step();
        eiv = 1'b0;
        #1 check_eq("bp_refill_sid", 64'(ch_sid[2*SID_W +: SID_W]), 64'h32);
        repeat (2) step();

        // Bubble ignores hazards and writes nothing
        eiv = 1'b1; uov = 8'hFF;
        put(1'b0, 8'hFF, 3, 8'h40);
        #1 check_eq("bubble_ack", 64'(decode_issue_ack), 64'd1);
        step();
        eiv = 1'b0;
        #1 check_eq("bubble_vld", 64'({irr_vld, ch_vld}), 64'd0);
        step();

        // Long stall saturates the 4-bit counter
        eiv = 1'b1; uov = 8'h80;
        put(1'b1, 8'h80, 0, 8'h50);
        repeat (20) step();
        check_eq("stall_sat", 64'(stall_cnt), 64'(SC_MAX));
        uov = 8'h00;
        step();
        eiv = 1'b0;
        step();

        // Random traffic with a mid-run reset
        for (int i = 0; i < 400; i++) begin
            rstn    = !(i == 200 || i == 201);
            eiv     = ($urandom_range(0, 9) < 8);
            uov     = UOV_W'($urandom_range(0, 255) & $urandom_range(0, 255));
            ch_rdy  = NUM_CH'($urandom | $urandom);
            irr_rdy = ($urandom_range(0, 3) != 0);
            put(($urandom_range(0, 9) != 0),
                ($urandom_range(0, 2) == 0) ? UOV_W'(1 << $urandom_range(0, 7)) : '0,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4)),
                SID_W'($urandom));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
